// File: rtl/ras_checkpoint_pipe.sv
// Carries RAS checkpoints and predictions from IF to EX, then checks the resolved target at EX.
// On a misprediction it issues a registered one-cycle restore request back to the return address stack.
module ras_checkpoint_pipe #(
   parameter int unsigned XLEN         = 32,
   parameter int unsigned RAS_DEPTH    = 8,
   parameter int unsigned RAS_PTR_BITS = $clog2(RAS_DEPTH),
   parameter int unsigned PIPE_DEPTH   = 2
) (
   input  logic                    i_clk,
   input  logic                    i_rst,
   input  logic                    i_stall,
   input  logic                    i_flush,
   input  logic                    i_if_valid,
   input  logic                    i_is_call,
   input  logic                    i_is_return,
   input  logic                    i_is_coroutine,
   input  logic                    i_ras_valid,
   input  logic [XLEN-1:0]         i_ras_target,
   input  logic [RAS_PTR_BITS-1:0] i_checkpoint_tos,
   input  logic [RAS_PTR_BITS:0]   i_checkpoint_valid_count,
   input  logic                    i_ex_resolve,
   input  logic [XLEN-1:0]         i_ex_actual_target,
   input  logic                    i_ex_redirect,
   output logic                    o_misprediction,
   output logic [RAS_PTR_BITS-1:0] o_restore_tos,
   output logic [RAS_PTR_BITS:0]   o_restore_valid_count,
   output logic                    o_pop_after_restore,
   output logic                    o_ras_resync,
   output logic [31:0]             o_mispredict_count
);

   typedef struct packed {
      logic                    valid;
      logic                    call;
      logic                    ret;
      logic                    coro;
      logic                    ras_valid;
      logic [XLEN-1:0]         ras_target;
      logic [RAS_PTR_BITS-1:0] ckpt_tos;
      logic [RAS_PTR_BITS:0]   ckpt_vc;
   } stage_t;

   stage_t stage_q [PIPE_DEPTH];
   stage_t stage_d [PIPE_DEPTH];
   stage_t ex;

   logic                    ret_like;
   logic                    tgt_miss;
   logic                    resync;
   logic                    detect;
   logic                    pop_req;

   logic                    misp_q;
   logic [RAS_PTR_BITS-1:0] tos_q;
   logic [RAS_PTR_BITS:0]   vc_q;
   logic                    pop_q;
   logic                    resync_q;
   logic [31:0]             cnt_q;

   always_comb begin
      ex       = stage_q[PIPE_DEPTH-1];
      ret_like = ex.ret | ex.coro;
      tgt_miss = ret_like & ex.ras_valid & (ex.ras_target != i_ex_actual_target);
      resync   = ex.ret & ~ex.coro & ~ex.ras_valid & (ex.ckpt_vc != '0);
      detect   = ~i_stall & ex.valid & i_ex_resolve & (tgt_miss | resync | i_ex_redirect);
      pop_req  = ex.ret & ~ex.coro & (ex.ckpt_vc != '0);
   end

   // A detect or flush kills every stage, including the one being captured this edge.
   always_comb begin
      for (int unsigned k = 0; k < PIPE_DEPTH; k++) begin
         stage_d[k] = stage_q[k];
      end
      if (!i_stall) begin
         stage_d[0].valid      = i_if_valid & ~i_flush & ~detect;
         stage_d[0].call       = i_is_call;
         stage_d[0].ret        = i_is_return;
         stage_d[0].coro       = i_is_coroutine;
         stage_d[0].ras_valid  = i_ras_valid;
         stage_d[0].ras_target = i_ras_target;
         stage_d[0].ckpt_tos   = i_checkpoint_tos;
         stage_d[0].ckpt_vc    = i_checkpoint_valid_count;
         for (int unsigned k = 1; k < PIPE_DEPTH; k++) begin
            stage_d[k]       = stage_q[k-1];
            stage_d[k].valid = stage_q[k-1].valid & ~i_flush & ~detect;
         end
      end else if (i_flush) begin
         for (int unsigned k = 0; k < PIPE_DEPTH; k++) begin
            stage_d[k].valid = 1'b0;
         end
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         for (int unsigned k = 0; k < PIPE_DEPTH; k++) begin
            stage_q[k] <= '0;
         end
         misp_q   <= 1'b0;
         tos_q    <= '0;
         vc_q     <= '0;
         pop_q    <= 1'b0;
         resync_q <= 1'b0;
         cnt_q    <= '0;
      end else begin
         for (int unsigned k = 0; k < PIPE_DEPTH; k++) begin
            stage_q[k] <= stage_d[k];
         end
         misp_q   <= detect;
         tos_q    <= detect ? ex.ckpt_tos : '0;
         vc_q     <= detect ? ex.ckpt_vc  : '0;
         pop_q    <= detect & pop_req;
         resync_q <= detect & resync & ~tgt_miss & ~i_ex_redirect;
         if (detect && tgt_miss) begin
            cnt_q <= cnt_q + 32'd1;
         end
      end
   end

   assign o_misprediction       = misp_q;
   assign o_restore_tos         = tos_q;
   assign o_restore_valid_count = vc_q;
   assign o_pop_after_restore   = pop_q;
   assign o_ras_resync          = resync_q;
   assign o_mispredict_count    = cnt_q;

endmodule

// File: tb/tb_ras_checkpoint_pipe.sv
// Directed bench for ras_checkpoint_pipe (XLEN=32, RAS_DEPTH=8, PIPE_DEPTH=2).
module tb_ras_checkpoint_pipe;

   logic        clk = 1'b0;
   logic        rst, stall, flush, if_valid, is_call, is_ret, is_coro, ras_valid;
   logic [31:0] ras_target, actual;
   logic [2:0]  ck_tos;
   logic [3:0]  ck_vc;
   logic        resolve, redirect;
   logic        misp, pop, rsync;
   logic [2:0]  r_tos;
   logic [3:0]  r_vc;
   logic [31:0] cnt;

   int compared   = 0;
   int mismatched = 0;

   always #5 clk = ~clk;

   ras_checkpoint_pipe #(.XLEN(32), .RAS_DEPTH(8), .PIPE_DEPTH(2)) dut (
      .i_clk(clk), .i_rst(rst), .i_stall(stall), .i_flush(flush),
      .i_if_valid(if_valid), .i_is_call(is_call), .i_is_return(is_ret),
      .i_is_coroutine(is_coro), .i_ras_valid(ras_valid), .i_ras_target(ras_target),
      .i_checkpoint_tos(ck_tos), .i_checkpoint_valid_count(ck_vc),
      .i_ex_resolve(resolve), .i_ex_actual_target(actual), .i_ex_redirect(redirect),
      .o_misprediction(misp), .o_restore_tos(r_tos), .o_restore_valid_count(r_vc),
      .o_pop_after_restore(pop), .o_ras_resync(rsync), .o_mispredict_count(cnt)
   );

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      compared++;
      assert (obs === exp) else begin
         mismatched++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic check_out(input string tag, input logic m, input logic [2:0] t,
                            input logic [3:0] v, input logic p, input logic rs, input logic [31:0] c);
      check({tag, ".misp"},   misp,  m);
      check({tag, ".tos"},    r_tos, t);
      check({tag, ".vc"},     r_vc,  v);
      check({tag, ".pop"},    pop,   p);
      check({tag, ".resync"}, rsync, rs);
      check({tag, ".count"},  cnt,   c);
   endtask

   // Present one instruction at IF for the next edge.
   task automatic load(input logic c, input logic r, input logic co, input logic rv,
                       input logic [31:0] tg, input logic [2:0] t, input logic [3:0] v);
      if_valid = 1'b1; is_call = c; is_ret = r; is_coro = co; ras_valid = rv;
      ras_target = tg; ck_tos = t; ck_vc = v;
   endtask

   task automatic idle_if();
      if_valid = 1'b0; is_call = 1'b0; is_ret = 1'b0; is_coro = 1'b0; ras_valid = 1'b0;
      ras_target = '0; ck_tos = '0; ck_vc = '0;
   endtask

   initial begin
      rst = 1'b1; stall = 1'b0; flush = 1'b0; resolve = 1'b0; redirect = 1'b0; actual = '0;
      idle_if();
      step(); step();
      check_out("reset", 1'b0, 3'd0, 4'd0, 1'b0, 1'b0, 32'd0);
      rst = 1'b0;

      // 1: correctly predicted return
      load(1'b0, 1'b1, 1'b0, 1'b1, 32'h100, 3'd3, 4'd4); step();
      idle_if(); step();
      resolve = 1'b1; actual = 32'h100; step();
      resolve = 1'b0;
      check_out("t1", 1'b0, 3'd0, 4'd0, 1'b0, 1'b0, 32'd0);

      // 2: same return, wrong target
      load(1'b0, 1'b1, 1'b0, 1'b1, 32'h100, 3'd3, 4'd4); step();
      idle_if(); step();
      resolve = 1'b1; actual = 32'h200; step();
      resolve = 1'b0;
      check_out("t2", 1'b1, 3'd3, 4'd4, 1'b1, 1'b0, 32'd1);
      step();
      check_out("t2.after", 1'b0, 3'd0, 4'd0, 1'b0, 1'b0, 32'd1);

      // 3: missed pop -> resync; vc=0 gives nothing
      load(1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 3'd1, 4'd2); step();
      idle_if(); step();
      resolve = 1'b1; actual = 32'h240; step();
      resolve = 1'b0;
      check_out("t3", 1'b1, 3'd1, 4'd2, 1'b1, 1'b1, 32'd1);
      load(1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 3'd0, 4'd0); step();
      idle_if(); step();
      resolve = 1'b1; actual = 32'h240; step();
      resolve = 1'b0;
      check_out("t3.vc0", 1'b0, 3'd0, 4'd0, 1'b0, 1'b0, 32'd1);

      // 4: redirected call with a younger mispredicting return behind it
      load(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 3'd7, 4'd8); step();
      load(1'b0, 1'b1, 1'b0, 1'b1, 32'h300, 3'd2, 4'd1); step();
      idle_if();
      resolve = 1'b1; redirect = 1'b1; actual = 32'h80; step();
      redirect = 1'b0; actual = 32'h999;
      check_out("t4", 1'b1, 3'd7, 4'd8, 1'b0, 1'b0, 32'd1);
      step();
      check_out("t4.drop1", 1'b0, 3'd0, 4'd0, 1'b0, 1'b0, 32'd1);
      step();
      check_out("t4.drop2", 1'b0, 3'd0, 4'd0, 1'b0, 1'b0, 32'd1);
      resolve = 1'b0;

      // 5: stall over a mismatching return in EX
      load(1'b0, 1'b1, 1'b0, 1'b1, 32'h400, 3'd2, 4'd3); step();
      idle_if(); step();
      resolve = 1'b1; actual = 32'h500; stall = 1'b1;
      for (int i = 0; i < 3; i++) begin
         step();
         check("t5.stalled.misp", misp, 1'b0);
      end
      stall = 1'b0; step();
      resolve = 1'b0;
      check_out("t5", 1'b1, 3'd2, 4'd3, 1'b1, 1'b0, 32'd2);
      step();
      check("t5.after.misp", misp, 1'b0);

      // 6: flush coincident with an EX mismatch
      load(1'b0, 1'b1, 1'b0, 1'b1, 32'h600, 3'd5, 4'd6); step();
      load(1'b0, 1'b1, 1'b0, 1'b1, 32'h700, 3'd4, 4'd5); step();
      resolve = 1'b1; actual = 32'h601; flush = 1'b1; step();
      flush = 1'b0; idle_if(); actual = 32'hdead;
      check_out("t6", 1'b1, 3'd5, 4'd6, 1'b1, 1'b0, 32'd3);
      step();
      check("t6.empty1.misp", misp, 1'b0);
      step();
      check("t6.empty2.misp", misp, 1'b0);
      resolve = 1'b0;

      // reset mid-stream with a mismatch sitting in EX
      load(1'b0, 1'b1, 1'b0, 1'b1, 32'h800, 3'd6, 4'd7); step();
      idle_if(); step();
      resolve = 1'b1; actual = 32'h801; rst = 1'b1; step();
      check_out("rst", 1'b0, 3'd0, 4'd0, 1'b0, 1'b0, 32'd0);
      rst = 1'b0; step();
      check_out("rst.after", 1'b0, 3'd0, 4'd0, 1'b0, 1'b0, 32'd0);
      resolve = 1'b0;

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
